miriscv_lsu_fsm: RTL
====================

Name: miriscv_lsu_fsm

Overview:
Parametrised load/store unit that replaces the single-cycle, store-only LSU path with a request/grant/response FSM.
- Supports XLEN of 32 or 64, and byte/half/word/dword accesses.
- Generates lane byte-enables and replicated store data; detects misalignment.
- Aligns and sign/zero-extends load data into a held result register.
- Drives a pipeline stall while a transaction is in flight.
- Sits between the execute stage and the data-memory port.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
BE_W, XLEN/8, byte-enable width (derived; do not override).
BYTE_ADDR_W, $clog2(XLEN/8), number of address bits selecting a byte lane (derived).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
data_req_o  out  1  memory request valid
data_gnt_i  in  1  memory accepted request this cycle
data_we_o  out  1  1 = store
data_be_o  out  BE_W  byte enables
data_addr_o  out  XLEN  byte address (unmodified)
data_wdata_o  out  XLEN  store data, lane-replicated
data_rvalid_i  in  1  response valid (one per granted request)
data_rdata_i  in  XLEN  response data
lsu_req_i  in  1  pipeline requests an access
lsu_kill_i  in  1  flush the current instruction
lsu_keep_i  in  1  pipeline holding; keep result in DONE
lsu_we_i  in  1  store
lsu_size_i  in  MEM_ACCESS_W  access type (package enum)
lsu_addr_i  in  XLEN  address
lsu_data_i  in  XLEN  store data (LSB-justified)
lsu_data_o  out  XLEN  formatted load result
lsu_stall_o  out  1  stall pipeline
lsu_misaligned_o  out  1  misaligned or illegal-size access (combinational)

Behaviour:
- States: IDLE, REQ, RESP, DRAIN, DONE. On reset: state=IDLE; data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, lsu_data_o=0.
- Legality (combinational on lsu_* inputs):
  - misaligned = half/uhalf with addr[0]≠0; word/uword with addr[1:0]≠0; dword with addr[2:0]≠0.
  - uword/dword with XLEN=32 is illegal and treated as misaligned.
  - lsu_misaligned_o = lsu_req_i & ~lsu_kill_i & misaligned & state==IDLE. No memory request is issued for such an access; stall stays 0.
- Accept (IDLE): when lsu_req_i & ~lsu_kill_i & ~misaligned:
  - Register addr, we, size, be, wdata. Go to REQ. lsu_stall_o=1 in this cycle.
  - be = size mask (1/3/F/FF) << addr[BYTE_ADDR_W-1:0], truncated to BE_W.
  - wdata replicates the low byte/half/word across all lanes; dword passes through unchanged.
- REQ: data_req_o=1 with stable address/control until data_gnt_i.
  - On gnt: go to RESP and drop data_req_o next cycle.
  - lsu_kill_i without gnt: go to IDLE, no transaction.
  - lsu_kill_i with gnt in the same cycle: go to DRAIN.
- RESP: wait for data_rvalid_i.
  - On rvalid: register lsu_data_o and go to DONE. Load formatting: select lane by addr[BYTE_ADDR_W-1:0], then sign- or zero-extend per size. For stores, lsu_data_o is unchanged.
  - lsu_kill_i: go to DRAIN (or directly to IDLE if rvalid arrives in the same cycle); the response is discarded.
- DRAIN: wait for rvalid, discard the data, go to IDLE. lsu_stall_o=lsu_req_i.
- DONE: lsu_stall_o=0; lsu_data_o held.
  - If lsu_keep_i & ~lsu_kill_i: stay in DONE.
  - Else: go to IDLE. No new acceptance in this cycle, so a request is never accepted twice.
- lsu_stall_o = 1 in REQ and RESP, in IDLE when accepting, and in DRAIN when lsu_req_i.
- Best case (gnt in REQ, rvalid the next cycle): lsu_stall_o high for 3 cycles (accept, REQ, RESP), then DONE.
- rvalid outside RESP/DRAIN is ignored.
- Reset asserted in any state returns the block to IDLE on the next edge; outstanding responses after reset are ignored.

Decomposition:
- miriscv_lsu_pkg holds:
  - MEM_ACCESS_W=3 and the enum MEM_ACCESS_BYTE/HALF/WORD/UBYTE/UHALF/UWORD/DWORD.
  - The lsu_state_e typedef.
  - A function size_mask(size) returning the unshifted byte mask.
- One sub-module, miriscv_lsu_load_fmt: a combinational lane select plus extension; inputs rdata, addr lsbs, size; output XLEN result.

Test Plan:
- XLEN=32, sb addr 0x1003 data 0xA5, gnt the same cycle as req: be=4'b1000, wdata=0xA5A5A5A5, data_we_o=1; lsu_stall_o=1 for 3 cycles, then DONE.
- XLEN=32, lh addr 0x2002, rdata 0x8001_1234: lsu_data_o=0xFFFF8001; lhu → 0x00008001; lb addr 0x2001 rdata 0x0000_F000 → 0xFFFFFFF0.
- XLEN=64, ld addr 0x10, gnt delayed 3 cycles, rdata 0x0123456789ABCDEF: data_req_o held 4 cycles with constant addr; lsu_data_o=0x0123456789ABCDEF.
- XLEN=64, lw addr 0x4 rdata 0x80000000_00000000: lsu_data_o=0xFFFFFFFF80000000.
- lw addr 0x1002: lsu_misaligned_o=1 for 1 cycle, data_req_o stays 0, stall=0. Same check for ld on XLEN=32.
- Kill in RESP, rvalid 2 cycles later, lsu_data_o previously 0x55: block goes via DRAIN to IDLE, lsu_data_o stays 0x55. A new lw issued during DRAIN sees stall=1 and is accepted in IDLE.
- lsu_keep_i=1 for 3 cycles in DONE: lsu_data_o stable, no new data_req_o; rst_i asserted in REQ → data_req_o=0 on the next cycle.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states
// and the unshifted byte-mask helper.
package miriscv_lsu_pkg;

    localparam int MEM_ACCESS_W = 3;

    typedef enum logic [MEM_ACCESS_W-1:0] {
        MEM_ACCESS_BYTE  = 3'd0,
        MEM_ACCESS_HALF  = 3'd1,
        MEM_ACCESS_WORD  = 3'd2,
        MEM_ACCESS_UBYTE = 3'd3,
        MEM_ACCESS_UHALF = 3'd4,
        MEM_ACCESS_UWORD = 3'd5,
        MEM_ACCESS_DWORD = 3'd6
    } mem_access_e;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_RESP  = 3'd2,
        LSU_DRAIN = 3'd3,
        LSU_DONE  = 3'd4
    } lsu_state_e;

    // Byte mask for an access of the given size, aligned to lane 0.
    // The unused encoding yields an empty mask.
    function automatic logic [7:0] size_mask(input logic [MEM_ACCESS_W-1:0] size);
        logic [7:0] mask;
        case (size)
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: mask = 8'h01;
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: mask = 8'h03;
            MEM_ACCESS_WORD, MEM_ACCESS_UWORD: mask = 8'h0F;
            MEM_ACCESS_DWORD:                  mask = 8'hFF;
            default:                           mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/miriscv_lsu_fsm_load_fmt.sv
// Load-data formatter: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to XLEN according to the access size.
module miriscv_lsu_load_fmt
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BYTE_ADDR_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]         rdata_i,
    input  logic [BYTE_ADDR_W-1:0]  addr_lsb_i,
    input  logic [MEM_ACCESS_W-1:0] size_i,
    output logic [XLEN-1:0]         result_o
);

    logic [XLEN-1:0] lane;

    // Lane select followed by extension; a dword is the full bus.
    always_comb begin
        lane     = rdata_i >> {addr_lsb_i, 3'b000};
        result_o = lane;
        case (size_i)
            MEM_ACCESS_BYTE:  result_o = XLEN'($signed(lane[7:0]));
            MEM_ACCESS_HALF:  result_o = XLEN'($signed(lane[15:0]));
            MEM_ACCESS_WORD:  result_o = XLEN'($signed(lane[31:0]));
            MEM_ACCESS_UBYTE: result_o = XLEN'(lane[7:0]);
            MEM_ACCESS_UHALF: result_o = XLEN'(lane[15:0]);
            MEM_ACCESS_UWORD: result_o = XLEN'(lane[31:0]);
            default:          result_o = lane;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu_fsm.sv
// Load/store unit: accepts one access from the pipeline, runs a
// request/grant/response exchange on the data port, and holds the
// formatted load result until the pipeline moves on.
//
// Handshake on the data port: data_req_o stays high with stable
// address/control until the cycle data_gnt_i is seen; each grant is
// followed by exactly one data_rvalid_i, which is only looked at in
// RESP or DRAIN.
module miriscv_lsu_fsm
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BE_W        = XLEN/8,
    parameter int BYTE_ADDR_W = $clog2(XLEN/8)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic                    data_we_o,
    output logic [BE_W-1:0]         data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i,

    input  logic                    lsu_req_i,
    input  logic                    lsu_kill_i,
    input  logic                    lsu_keep_i,
    input  logic                    lsu_we_i,
    input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
    input  logic [XLEN-1:0]         lsu_addr_i,
    input  logic [XLEN-1:0]         lsu_data_i,
    output logic [XLEN-1:0]         lsu_data_o,
    output logic                    lsu_stall_o,
    output logic                    lsu_misaligned_o
);

    lsu_state_e              state_q, state_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [MEM_ACCESS_W-1:0] size_q, size_d;
    logic                    we_q, we_d;

    logic                    misaligned;
    logic                    accept;
    logic [15:0]             be_wide;
    logic [BE_W-1:0]         be_new;
    logic [XLEN-1:0]         wdata_new;
    logic [XLEN-1:0]         load_result;

    // Alignment and size legality of the access on the pipeline inputs.
    always_comb begin
        misaligned = 1'b1;
        case (lsu_size_i)
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: misaligned = 1'b0;
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: misaligned = lsu_addr_i[0];
            MEM_ACCESS_WORD:  misaligned = |lsu_addr_i[1:0];
            MEM_ACCESS_UWORD: misaligned = (XLEN == 32) || (|lsu_addr_i[1:0]);
            MEM_ACCESS_DWORD: misaligned = (XLEN == 32) || (|lsu_addr_i[2:0]);
            default:          misaligned = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for a new access.
    always_comb begin
        be_wide = 16'(size_mask(lsu_size_i)) << lsu_addr_i[BYTE_ADDR_W-1:0];
        be_new  = be_wide[BE_W-1:0];
        case (lsu_size_i)
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: wdata_new = {BE_W{lsu_data_i[7:0]}};
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: wdata_new = {(BE_W/2){lsu_data_i[15:0]}};
            MEM_ACCESS_WORD, MEM_ACCESS_UWORD: wdata_new = {(BE_W/4){lsu_data_i[31:0]}};
            default:                           wdata_new = lsu_data_i;
        endcase
    end

    assign accept           = (state_q == LSU_IDLE) & lsu_req_i & ~lsu_kill_i & ~misaligned;
    assign lsu_misaligned_o = (state_q == LSU_IDLE) & lsu_req_i & ~lsu_kill_i & misaligned;

    miriscv_lsu_load_fmt #(
        .XLEN        (XLEN),
        .BYTE_ADDR_W (BYTE_ADDR_W)
    ) u_load_fmt (
        .rdata_i    (data_rdata_i),
        .addr_lsb_i (addr_q[BYTE_ADDR_W-1:0]),
        .size_i     (size_q),
        .result_o   (load_result)
    );

    // Next-state, capture and stall logic of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        be_d        = be_q;
        size_d      = size_q;
        we_d        = we_q;
        lsu_stall_o = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    addr_d      = lsu_addr_i;
                    wdata_d     = wdata_new;
                    be_d        = be_new;
                    size_d      = lsu_size_i;
                    we_d        = lsu_we_i;
                    lsu_stall_o = 1'b1;
                    state_d     = LSU_REQ;
                end
            end
            LSU_REQ: begin
                lsu_stall_o = 1'b1;
                if (lsu_kill_i && data_gnt_i) begin
                    state_d = LSU_DRAIN;
                end else if (lsu_kill_i) begin
                    state_d = LSU_IDLE;
                end else if (data_gnt_i) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                lsu_stall_o = 1'b1;
                if (data_rvalid_i) begin
                    if (lsu_kill_i) begin
                        state_d = LSU_IDLE;
                    end else begin
                        if (!we_q) begin
                            rdata_d = load_result;
                        end
                        state_d = LSU_DONE;
                    end
                end else if (lsu_kill_i) begin
                    state_d = LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                lsu_stall_o = lsu_req_i;
                if (data_rvalid_i) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_DONE: begin
                // Returning to IDLE without accepting keeps a held request
                // from being issued a second time.
                if (!(lsu_keep_i && !lsu_kill_i)) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            size_q  <= size_d;
            we_q    <= we_d;
        end
    end

    assign data_req_o   = (state_q == LSU_REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;
    assign lsu_data_o   = rdata_q;

endmodule
